ex_muldiv: RTL and testbench

Iterative multiply/divide unit in EX. It consumes the HI/LO operation request that ID forwards with the instruction (MULT, MULTU, DIV, DIVU) and produces the 64-bit {HI, LO} result. It runs one bit per cycle, radix-2, and holds the pipeline through the stall controller while busy. Results go onto the EX→MEM HI/LO write path.

---
 rtl/ex_muldiv.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for EX: shift-add multiply and restoring divide,
// one bit per cycle, holding the pipeline through stallreq while an operation is in flight.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             a_neg_q, a_neg_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, mul_prod;
  logic [WIDTH:0]   div_rem, div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  logic [WIDTH-1:0] quo, rem;
  logic             last_iter, can_accept;

  always_comb begin
    signed_op = ~op[0];
    a_abs     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    b_abs     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_prod = neg_q ? -mul_next : mul_next;

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    div_rem  = acc_q[W2-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    // Divide by zero leaves quotient all ones unnegated; the remainder sign rule restores src_a.
    quo = (neg_q && !bz_q) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem = a_neg_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];

    last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
    can_accept = (state_q == StIdle) || (state_q == StDone);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    a_neg_d = a_neg_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && !cancel) begin
          cnt_d   = '0;
          neg_d   = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          a_neg_d = signed_op && src_a[WIDTH-1];
          bz_d    = (src_b == '0);
          if (op[1]) begin
            state_d = StDivRun;
            acc_d   = {{WIDTH{1'b0}}, a_abs};
            opnd_d  = b_abs;
          end else begin
            state_d = StMulRun;
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            opnd_d  = a_abs;
          end
        end
      end
      StMulRun, StDivRun: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = (state_q == StMulRun) ? mul_next : div_next;
          if (last_iter) begin
            state_d = StDone;
            if (state_q == StMulRun) begin
              hi_d = mul_prod[W2-1:WIDTH];
              lo_d = mul_prod[WIDTH-1:0];
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stallreq  = (can_accept && start && !cancel) ||
                     (state_q == StMulRun) || (state_q == StDivRun);
  assign done      = (state_q == StDone);
  assign hi_result = hi_q;
  assign lo_result = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed operations push expected {hi, lo, done cycle};
// a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stallreq, done;
  logic [31:0] hi_result, lo_result;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int          k;

  ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .stallreq  (stallreq),
    .done      (done),
    .hi_result (hi_result),
    .lo_result (lo_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hi_result", {32'b0, hi_result}, {32'b0, e.hi});
        chk("lo_result", {32'b0, lo_result}, {32'b0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       output int c);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    c     = cyc;
    if (push) begin
      sb_q.push_back('{hi: ehi, lo: elo, cyc: cyc + 33});
      last_hi = ehi;
      last_lo = elo;
    end
    @(negedge clk);
    chk("stallreq_on_start", {63'b0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("stallreq_in_done", {63'b0, stallreq}, 64'd0);
        return;
      end
      chk("stallreq_busy", {63'b0, stallreq}, 64'd1);
    end
    chk("done_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int c;
    issue(o, a, b, 1'b1, ehi, elo, c);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] ehi,
                                    input logic [31:0] elo);
    chk({tag, "_done"}, {63'b0, done}, 64'd0);
    chk({tag, "_stallreq"}, {63'b0, stallreq}, 64'd0);
    chk({tag, "_hi"}, {32'b0, hi_result}, {32'b0, ehi});
    chk({tag, "_lo"}, {32'b0, lo_result}, {32'b0, elo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // MULT / MULTU
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    // DIV / DIVU including overflow and divide by zero
    run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

    // Cancel in cycle 10: no done, stallreq drops, results held
    issue(2'b01, 32'd5, 32'd6, 1'b0, '0, '0, k);
    repeat (8) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("stallreq_cancel_cycle", {63'b0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("stallreq_after_cancel", {63'b0, stallreq}, 64'd0);
    end
    check_idle_outputs("after_cancel", last_hi, last_lo);

    // Reset in cycle 10: everything back to zero, no done
    issue(2'b01, 32'd5, 32'd6, 1'b0, '0, '0, k);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("stallreq_after_rst", {63'b0, stallreq}, 64'd0);
    end
    check_idle_outputs("after_rst", 32'h0, 32'h0);

    // Back-to-back: DIVU 9/4, ignored start mid-run, then MULTU 3x3 accepted in DONE
    issue(2'b11, 32'd9, 32'd4, 1'b1, 32'd1, 32'd2, k);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd1;
    src_b = 32'd1;
    @(negedge clk);
    chk("stallreq_start_in_run", {63'b0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (cyc >= k + 33) break;
    end
    start = 1'b1;
    op    = 2'b01;
    src_a = 32'd3;
    src_b = 32'd3;
    sb_q.push_back('{hi: 32'd0, lo: 32'd9, cyc: cyc + 33});
    @(negedge clk);
    chk("b2b_first_done", {63'b0, done}, 64'd1);
    chk("b2b_stallreq_in_done", {63'b0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
